// File: rtl/fm_pkg.sv
// Shared definitions for the FM demodulator: default widths, the FSM state
// type, the offset-binary midscale helper and a signed saturation helper.
package fm_pkg;

    localparam int A_DEF = 8;
    localparam int D_DEF = 5;

    typedef enum logic {
        SYNC    = 1'b0,
        MEASURE = 1'b1
    } fm_state_e;

    // Midscale code of a d-bit offset-binary sample.
    function automatic int mid_of(input int d);
        return 1 << (d - 1);
    endfunction

    // Clamp a signed value into the range of an a-bit two's complement word.
    function automatic logic signed [31:0] sat_signed(input logic signed [63:0] v,
                                                      input int                 a);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (a - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (a - 1));
        if (v > hi) begin
            return hi[31:0];
        end else if (v < lo) begin
            return lo[31:0];
        end else begin
            return v[31:0];
        end
    endfunction

endpackage

// File: rtl/fm_zero_cross_detector.sv
// Rising midscale crossing detector for the offset-binary rf stream.
// The sample is registered once; a crossing is flagged when the registered
// sample is at or above midscale after a low excursion armed the detector.
// Build option FM_DEMOD_HYST_EN: the low excursion must reach MID-HYST, so
// glitches hovering just under midscale do not re-arm the detector.
module fm_zero_cross_detector
    import fm_pkg::*;
#(
    parameter int D    = D_DEF,
    parameter int HYST = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [D-1:0] rf,
    output logic         xing
);

    localparam logic [D-1:0] MID = D'(mid_of(D));

`ifdef FM_DEMOD_HYST_EN
    localparam bit HYST_ON = 1'b1;
`else
    localparam bit HYST_ON = 1'b0;
`endif

    // Without hysteresis "below MID" is the same as "at or below MID-1".
    localparam logic [D-1:0] ARM_TH = D'(mid_of(D) - (HYST_ON ? HYST : 1));

    logic [D-1:0] rf_q;
    logic         armed;

    assign xing = armed && (rf_q >= MID);

    // Sample register and arm flag; a crossing consumes the arm.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_q  <= MID;
            armed <= 1'b0;
        end else begin
            rf_q <= rf;
            if (xing) begin
                armed <= 1'b0;
            end else if (rf_q <= ARM_TH) begin
                armed <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/fm_demodulator.sv
// Period-counting FM discriminator. Times 2**P rising midscale crossings,
// subtracts the window length from nom_sum, scales by gain_shift and
// saturates to an A-bit signed audio sample. Windows are contiguous: the
// crossing that closes one window opens the next. A window that runs the
// counter into saturation is reported as lost lock and the FSM resyncs.
// Build option FM_DEMOD_HYST_EN: hysteresis in the crossing detector.
//
// state   | meaning
// --------+-------------------------------------------------------------
// SYNC    | counter idle, waiting for the first crossing to open a window
// MEASURE | counting cycles and crossings of the current window
module fm_demodulator
    import fm_pkg::*;
#(
    parameter int A    = A_DEF,
    parameter int D    = D_DEF,
    parameter int P    = 4,
    parameter int C    = 16,
    parameter int L    = 2,
    parameter int HYST = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [D-1:0]        rf,
    input  logic [C-1:0]        nom_sum,
    input  logic [L-1:0]        gain_shift,
    output logic signed [A-1:0] audio,
    output logic                audio_valid,
    output logic                lost_lock
);

    localparam logic [C-1:0] CNT_MAX   = '1;
    localparam logic [P-1:0] XCNT_LAST = '1;
    // Deviation is C+1 bits; the largest shift adds 2**L-1 more.
    localparam int           SW        = C + (2 ** L);

    fm_state_e   state;
    fm_state_e   state_nxt;
    logic [C-1:0] cnt;
    logic [C-1:0] cnt_nxt;
    logic [P-1:0] xcnt;
    logic [P-1:0] xcnt_nxt;
    logic [C-1:0] meas;
    logic [C-1:0] meas_nxt;
    logic         pend;
    logic         pend_nxt;
    logic         pend_to;
    logic         pend_to_nxt;
    logic         xing;

    logic signed [C:0]    dev;
    logic signed [SW-1:0] sdev;
    logic signed [A-1:0]  audio_sat;

    fm_zero_cross_detector #(
        .D    (D),
        .HYST (HYST)
    ) u_zcd (
        .clk  (clk),
        .rst  (rst),
        .rf   (rf),
        .xing (xing)
    );

    // State and window bookkeeping registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= SYNC;
            cnt     <= '0;
            xcnt    <= '0;
            meas    <= '0;
            pend    <= 1'b0;
            pend_to <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            xcnt    <= xcnt_nxt;
            meas    <= meas_nxt;
            pend    <= pend_nxt;
            pend_to <= pend_to_nxt;
        end
    end

    // Next-state logic; saturation is checked before the crossing so a
    // crossing landing on the saturated cycle is ignored.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        xcnt_nxt    = xcnt;
        meas_nxt    = meas;
        pend_nxt    = 1'b0;
        pend_to_nxt = 1'b0;
        case (state)
            SYNC: begin
                if (xing) begin
                    state_nxt = MEASURE;
                    cnt_nxt   = C'(1);
                    xcnt_nxt  = '0;
                end
            end
            MEASURE: begin
                if (cnt == CNT_MAX) begin
                    meas_nxt    = cnt;
                    pend_nxt    = 1'b1;
                    pend_to_nxt = 1'b1;
                    state_nxt   = SYNC;
                    cnt_nxt     = '0;
                    xcnt_nxt    = '0;
                end else if (xing && (xcnt == XCNT_LAST)) begin
                    meas_nxt = cnt;
                    pend_nxt = 1'b1;
                    cnt_nxt  = C'(1);
                    xcnt_nxt = '0;
                end else begin
                    cnt_nxt = cnt + C'(1);
                    if (xing) begin
                        xcnt_nxt = xcnt + P'(1);
                    end
                end
            end
            default: begin
                state_nxt = SYNC;
            end
        endcase
    end

    // Deviation from nominal, gain shift and saturation of the held window.
    always_comb begin
        dev       = $signed({1'b0, nom_sum}) - $signed({1'b0, meas});
        sdev      = SW'(dev) <<< gain_shift;
        audio_sat = A'(sat_signed(64'(sdev), A));
    end

    // Output stage; nom_sum and gain_shift take effect here, at emission.
    always_ff @(posedge clk) begin
        if (rst) begin
            audio       <= '0;
            audio_valid <= 1'b0;
            lost_lock   <= 1'b0;
        end else begin
            audio_valid <= pend;
            if (pend) begin
                audio     <= audio_sat;
                lost_lock <= pend_to;
            end
        end
    end

endmodule

// File: tb/tb_fm_demodulator.sv
// Bench for fm_demodulator: directed waveforms plus random square waves,
// compared every cycle against a window-level reference model.
module tb_fm_demodulator;

    localparam int     A    = 8;
    localparam int     D    = 5;
    localparam int     P    = 4;
    localparam int     C    = 16;
    localparam int     L    = 2;
    localparam int     HYST = 2;
    localparam int     MID  = 16;
    localparam int     XPW  = 16;
    localparam longint CMAX = 65535;

    logic                clk = 1'b0;
    logic                rst;
    logic [D-1:0]        rf;
    logic [C-1:0]        nom_sum;
    logic [L-1:0]        gain_shift;
    logic signed [A-1:0] audio;
    logic                audio_valid;
    logic                lost_lock;

    always #5 clk = ~clk;

    fm_demodulator #(
        .A(A), .D(D), .P(P), .C(C), .L(L), .HYST(HYST)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rf          (rf),
        .nom_sum     (nom_sum),
        .gain_shift  (gain_shift),
        .audio       (audio),
        .audio_valid (audio_valid),
        .lost_lock   (lost_lock)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: crossing times and window lengths in clock edges.
    longint edge_n     = 0;
    int     m_prev     = MID;
    bit     m_low_seen = 1'b0;
    bit     m_locked   = 1'b0;
    longint m_start    = 0;
    int     m_xings    = 0;
    bit     m_pend     = 1'b0;
    longint m_pend_len = 0;
    bit     m_pend_to  = 1'b0;
    int     m_audio    = 0;
    bit     m_valid    = 1'b0;
    bit     m_lost     = 1'b0;

    int seg_valids = 0;
    int last_audio = 0;
    int ph         = 0;

    task automatic chk(input string tag, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic int clamp_a(input longint v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return int'(v);
    endfunction

    function automatic bit is_low(input int s);
`ifdef FM_DEMOD_HYST_EN
        return s <= MID - HYST;
`else
        return s < MID;
`endif
    endfunction

    task automatic model_edge();
        bit crossed;
        edge_n++;
        if (rst) begin
            m_prev = MID; m_low_seen = 0; m_locked = 0; m_xings = 0;
            m_pend = 0; m_audio = 0; m_valid = 0; m_lost = 0;
            return;
        end
        m_valid = 0;
        if (m_pend) begin
            m_audio = clamp_a((longint'(nom_sum) - m_pend_len) * (longint'(1) << gain_shift));
            m_valid = 1;
            m_lost  = m_pend_to;
            m_pend  = 0;
        end
        crossed = m_low_seen && (m_prev >= MID);
        if (crossed) m_low_seen = 0;
        else if (is_low(m_prev)) m_low_seen = 1;
        if (m_locked) begin
            if (edge_n - m_start >= CMAX) begin
                m_pend = 1; m_pend_len = CMAX; m_pend_to = 1; m_locked = 0;
            end else if (crossed) begin
                m_xings++;
                if (m_xings == XPW) begin
                    m_pend = 1; m_pend_len = edge_n - m_start; m_pend_to = 0;
                    m_start = edge_n; m_xings = 0;
                end
            end
        end else if (crossed) begin
            m_locked = 1; m_start = edge_n; m_xings = 0;
        end
        m_prev = int'(rf);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_edge();
        chk("audio_valid", longint'(audio_valid), longint'(m_valid));
        chk("audio", longint'($signed(audio)), longint'(m_audio));
        chk("lost_lock", longint'(lost_lock), longint'(m_lost));
        if (audio_valid) begin
            seg_valids++;
            last_audio = int'($signed(audio));
        end
    endtask

    task automatic square(input int lo, input int hi, input int lo_v, input int hi_v,
                          input int cycles);
        for (int c = 0; c < cycles; c++) begin
            rf = D'((ph < lo) ? lo_v : hi_v);
            tick();
            ph = (ph + 1) % (lo + hi);
        end
    endtask

    initial begin
        int lo_len, hi_len, wait_cnt;
        rst = 1'b1; rf = D'(MID); nom_sum = 16'd256; gain_shift = '0;
        repeat (3) tick();
        rst = 1'b0;
        chk("reset_audio", longint'($signed(audio)), 0);
        chk("reset_lost", longint'(lost_lock), 0);

        // Period 16 at nominal: zero audio, one sample per 256 cycles.
        ph = 0; seg_valids = 0;
        square(8, 8, 8, 24, 256 * 4 + 40);
        chk("p16_count", seg_valids, 4);
        chk("p16_audio", last_audio, 0);

        // Period 15: +16 at unity gain, +64 with gain_shift 2.
        ph = 0; seg_valids = 0;
        square(8, 7, 8, 24, 240 * 4);
        chk("p15_g0", last_audio, 16);
        gain_shift = 2'd2;
        square(8, 7, 8, 24, 240 * 2);
        chk("p15_g2", last_audio, 64);

        // Clamp boundaries.
        gain_shift = 2'd3;
        ph = 0;
        square(4, 4, 8, 24, 128 * 4);
        chk("p8_clamp_hi", last_audio, 127);
        ph = 0;
        square(16, 16, 8, 24, 512 * 4);
        chk("p32_clamp_lo", last_audio, -128);

        // Rf dithering 15/16 around midscale.
        gain_shift = 2'd0; ph = 0; seg_valids = 0;
        square(1, 1, 15, 16, 32 * 8);
`ifdef FM_DEMOD_HYST_EN
        chk("dither_hyst_count", seg_valids, 0);
`else
        chk("dither_audio", last_audio, 127);
`endif

        // Random square waves, levels and configuration.
        for (int s = 0; s < 5; s++) begin
            lo_len     = int'($urandom_range(1, 20));
            hi_len     = int'($urandom_range(1, 20));
            nom_sum    = C'($urandom_range(0, 1200));
            gain_shift = L'($urandom_range(0, 3));
            ph = 0;
            for (int c = 0; c < 700; c++) begin
                rf = D'((ph < lo_len) ? $urandom_range(0, MID - 1)
                                      : $urandom_range(MID, 2 * MID - 1));
                tick();
                ph = (ph + 1) % (lo_len + hi_len);
            end
        end

        // Reset 100 cycles into a window.
        nom_sum = 16'd256; gain_shift = '0; ph = 0; seg_valids = 0;
        wait_cnt = 0;
        while (seg_valids < 2 && wait_cnt < 2000) begin
            square(8, 8, 8, 24, 1);
            wait_cnt++;
        end
        chk("pre_rst_lock", longint'(seg_valids >= 2), 1);
        square(8, 8, 8, 24, 99);
        rst = 1'b1;
        square(8, 8, 8, 24, 1);
        rst = 1'b0;
        chk("mid_rst_audio", longint'($signed(audio)), 0);
        chk("mid_rst_valid", longint'(audio_valid), 0);
        seg_valids = 0;
        square(8, 8, 8, 24, 200);
        chk("post_rst_quiet", seg_valids, 0);
        square(8, 8, 8, 24, 400);
        chk("post_rst_audio", last_audio, 0);

        // Loss of signal: counter saturates, then the stream resumes.
        seg_valids = 0;
        rf = D'(8);
        for (int c = 0; c < 65540; c++) tick();
        chk("timeout_count", seg_valids, 1);
        chk("timeout_audio", last_audio, -128);
        chk("timeout_lost", longint'(lost_lock), 1);
        ph = 0;
        square(8, 8, 8, 24, 600);
        chk("relock_lost", longint'(lost_lock), 0);
        chk("relock_audio", last_audio, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
